// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory bus port between instruction fetch (IF) and the
//           MEM stage, MEM first; optional fairness build (ARB_FAIR_EN) caps
//           consecutive MEM grants while IF waits at MAX_MEM_BURST.
// Latency : request seen in IDLE at cycle 0, bus_req at cycle 1, ack at cycle 2
//           with zero wait states; each bus_ready=0 cycle adds one cycle.
// Backpressure: bus_ready=0 holds BUSY with all bus outputs stable; stall_if /
//           stall_pipe freeze the requesting stages until their ack pulse.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   if_req/if_addr -> if_ack/if_rdata                      fetch requester
//   memread_mem/memwrite_mem/alu_result_mem/writedata_mem
//                  -> mem_ack/mem_rdata                    load/store requester
//   stall_if, stall_pipe           pipeline freeze controls
//   bus_req/bus_we/bus_addr/bus_wdata, bus_rdata/bus_ready memory bus
module mem_port_arbiter #(
    parameter int XLEN          = 64,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            memread_mem,
    input  logic            memwrite_mem,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] writedata_mem,
    output logic            mem_ack,
    output logic [XLEN-1:0] mem_rdata,
    output logic            stall_if,
    output logic            stall_pipe,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSY_IF  = 3'd1,
        BUSY_MEM = 3'd2,
        DONE_IF  = 3'd3,
        DONE_MEM = 3'd4
    } state_t;

    generate
        if (MAX_MEM_BURST < 1 || MAX_MEM_BURST > 15) begin : g_bad_burst
            $error("MAX_MEM_BURST must be in 1..15");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [XLEN-1:0] bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
    logic            bus_we_q, bus_we_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;

    logic mem_pend;
    logic force_if;
    logic grant_mem;
    logic grant_if;

    assign mem_pend = memread_mem | memwrite_mem;

`ifdef ARB_FAIR_EN
    // Counts MEM grants made while IF is kept waiting; once it reaches the
    // burst limit, the next contested IDLE cycle goes to IF.
    logic [3:0] burst_cnt_q, burst_cnt_d;

    assign force_if = (burst_cnt_q == 4'(MAX_MEM_BURST)) & mem_pend & if_req;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE) begin
            if (grant_if || !if_req) begin
                burst_cnt_d = '0;
            end else if (grant_mem && burst_cnt_q != 4'hF) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign grant_mem = (state_q == IDLE) & mem_pend & ~force_if;
    assign grant_if  = (state_q == IDLE) & if_req & (~mem_pend | force_if);

    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d     = BUSY_MEM;
                    bus_addr_d  = alu_result_mem;
                    bus_wdata_d = writedata_mem;
                    bus_we_d    = memwrite_mem;
                end else if (grant_if) begin
                    // Fetches leave bus_wdata at its last value.
                    state_d    = BUSY_IF;
                    bus_addr_d = if_addr;
                    bus_we_d   = 1'b0;
                end
            end
            BUSY_IF: begin
                if (bus_ready) begin
                    state_d    = DONE_IF;
                    if_rdata_d = bus_rdata;
                    bus_we_d   = 1'b0;
                end
            end
            BUSY_MEM: begin
                if (bus_ready) begin
                    state_d  = DONE_MEM;
                    bus_we_d = 1'b0;
                    // Stores keep the previous load result.
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end
            end
            DONE_IF:  state_d = IDLE;
            DONE_MEM: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Decoded straight from the state flop so reset drops bus_req at once.
    assign bus_req   = (state_q == BUSY_IF) | (state_q == BUSY_MEM);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_ack    = (state_q == DONE_IF);
    assign mem_ack   = (state_q == DONE_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign stall_pipe = mem_pend & ~mem_ack;
    assign stall_if   = stall_pipe | (if_req & ~if_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter (scoreboard + directed).
// Latency : n/a (testbench).
// Backpressure: bus slave inserts a programmable number of wait cycles.
module tb_mem_port_arbiter;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ack;
    logic [XLEN-1:0] if_rdata;
    logic            memread_mem;
    logic            memwrite_mem;
    logic [XLEN-1:0] alu_result_mem;
    logic [XLEN-1:0] writedata_mem;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            stall_if;
    logic            stall_pipe;
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ready;

    mem_port_arbiter #(.XLEN(XLEN), .MAX_MEM_BURST(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
        .alu_result_mem(alu_result_mem), .writedata_mem(writedata_mem),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_pipe(stall_pipe),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [63:0] addr; bit we; logic [63:0] wdata; } bus_t;
    typedef struct { bit is_if; logic [63:0] rdata; } ack_t;
    bus_t exp_bus[$];
    ack_t exp_ack[$];
    bus_t eb;
    ack_t ea;

    // Bus slave: fixed data pattern per address, programmable wait states.
    function automatic logic [63:0] rdata_of(input logic [63:0] a);
        if (a == 64'h100) return 64'h0000_0000_DEAD_BEEF;
        return {a[31:0], ~a[31:0]};
    endfunction

    int wait_target = 0;
    int wait_cnt = 0;
    assign bus_rdata = rdata_of(bus_addr);
    assign bus_ready = bus_req && (wait_cnt >= wait_target);
    always @(posedge clk) begin
        if (bus_req && !bus_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_load(input bit is_if, input logic [63:0] a, input logic [63:0] rd);
        exp_bus.push_back('{addr: a, we: 1'b0, wdata: 64'h0});
        exp_ack.push_back('{is_if: is_if, rdata: rd});
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a bus beat or acks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_req && bus_ready) begin
                if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: addr %h, no transaction expected", bus_addr);
                end else begin
                    eb = exp_bus.pop_front();
                    chk("bus_addr", bus_addr, eb.addr);
                    chk("bus_we", 64'(bus_we), 64'(eb.we));
                    if (eb.we) chk("bus_wdata", bus_wdata, eb.wdata);
                end
            end
            if (if_ack || mem_ack) begin
                chk("ack_onehot", 64'(if_ack & mem_ack), 64'd0);
                if (exp_ack.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: if_ack %b mem_ack %b, none expected", if_ack, mem_ack);
                end else begin
                    ea = exp_ack.pop_front();
                    chk("ack_source_is_if", 64'(if_ack), 64'(ea.is_if));
                    chk("ack_rdata", if_ack ? if_rdata : mem_rdata, ea.rdata);
                end
            end
        end
    end

    task automatic cyc_next();
        @(posedge clk);
        #1;
    endtask

    // Presents one MEM-stage access, holds it until acked, then advances the
    // pipeline on the edge that ends the DONE cycle.
    task automatic mem_op(input bit we, input logic [63:0] a, input logic [63:0] wd);
        int n;
        memread_mem = !we; memwrite_mem = we; alu_result_mem = a; writedata_mem = wd;
        n = 0;
        @(negedge clk);
        while (!mem_ack && n < 200) begin @(negedge clk); n++; end
        if (!mem_ack) begin
            checks++; errors++;
            $display("FAIL mem_ack_timeout: addr %h not acked within 200 cycles", a);
        end
        cyc_next();
    endtask

    task automatic if_op(input logic [63:0] a);
        int n;
        if_req = 1'b1; if_addr = a;
        n = 0;
        @(negedge clk);
        while (!if_ack && n < 200) begin @(negedge clk); n++; end
        if (!if_ack) begin
            checks++; errors++;
            $display("FAIL if_ack_timeout: addr %h not acked within 200 cycles", a);
        end
        cyc_next();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] s1_req, s1_ack, s1_stall;
        bit [5:0] s3_stall_if, s3_mack, s3_iack;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; memread_mem = 1'b0; memwrite_mem = 1'b0;
        alu_result_mem = '0; writedata_mem = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_bus_we", 64'(bus_we), 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_bus_wdata", bus_wdata, 64'd0);
        chk("rst_acks", 64'({if_ack, mem_ack}), 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_mem_rdata", mem_rdata, 64'd0);
        chk("rst_stalls", 64'({stall_if, stall_pipe}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc_next();

        // Single load, zero wait states.
        s1_req = 4'b0010; s1_ack = 4'b0100; s1_stall = 4'b0011;
        push_load(1'b0, 64'h100, 64'h0000_0000_DEAD_BEEF);
        memread_mem = 1'b1; alu_result_mem = 64'h100;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) cyc_next();
            if (c == 3) memread_mem = 1'b0;
            @(negedge clk);
            chk($sformatf("load_bus_req_c%0d", c), 64'(bus_req), 64'(s1_req[c]));
            chk($sformatf("load_mem_ack_c%0d", c), 64'(mem_ack), 64'(s1_ack[c]));
            chk($sformatf("load_stall_pipe_c%0d", c), 64'(stall_pipe), 64'(s1_stall[c]));
            if (c == 1) begin
                chk("load_bus_addr_c1", bus_addr, 64'h100);
                chk("load_bus_we_c1", 64'(bus_we), 64'd0);
            end
        end
        cyc_next();

        // Store with three wait states.
        wait_target = 3;
        exp_bus.push_back('{addr: 64'h200, we: 1'b1, wdata: 64'h55});
        exp_ack.push_back('{is_if: 1'b0, rdata: 64'h0000_0000_DEAD_BEEF});
        memwrite_mem = 1'b1; alu_result_mem = 64'h200; writedata_mem = 64'h55;
        for (int c = 1; c <= 4; c++) begin
            cyc_next();
            @(negedge clk);
            chk($sformatf("store_bus_req_c%0d", c), 64'(bus_req), 64'd1);
            chk($sformatf("store_bus_we_c%0d", c), 64'(bus_we), 64'd1);
            chk($sformatf("store_bus_wdata_c%0d", c), bus_wdata, 64'h55);
            chk($sformatf("store_bus_addr_c%0d", c), bus_addr, 64'h200);
        end
        cyc_next();
        @(negedge clk);
        chk("store_mem_ack_c5", 64'(mem_ack), 64'd1);
        cyc_next();
        memwrite_mem = 1'b0; wait_target = 0;
        cyc_next();

        // IF and MEM together: MEM first, IF acked three cycles after mem_ack.
        s3_stall_if = 6'b011111; s3_mack = 6'b000100; s3_iack = 6'b100000;
        push_load(1'b0, 64'h300, 64'h0000_0300_FFFF_FCFF);
        push_load(1'b1, 64'h1000, 64'h0000_1000_FFFF_EFFF);
        memread_mem = 1'b1; alu_result_mem = 64'h300; if_req = 1'b1; if_addr = 64'h1000;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc_next();
            if (c == 3) memread_mem = 1'b0;
            @(negedge clk);
            chk($sformatf("both_stall_if_c%0d", c), 64'(stall_if), 64'(s3_stall_if[c]));
            chk($sformatf("both_mem_ack_c%0d", c), 64'(mem_ack), 64'(s3_mack[c]));
            chk($sformatf("both_if_ack_c%0d", c), 64'(if_ack), 64'(s3_iack[c]));
        end
        cyc_next();
        if_req = 1'b0;
        cyc_next();

        // Five loads with IF fetching throughout; grant order depends on build.
`ifdef ARB_FAIR_EN
        push_load(1'b0, 64'h400,  64'h0000_0400_FFFF_FBFF);
        push_load(1'b0, 64'h500,  64'h0000_0500_FFFF_FAFF);
        push_load(1'b1, 64'h2000, 64'h0000_2000_FFFF_DFFF);
        push_load(1'b0, 64'h600,  64'h0000_0600_FFFF_F9FF);
        push_load(1'b0, 64'h700,  64'h0000_0700_FFFF_F8FF);
        push_load(1'b1, 64'h2008, 64'h0000_2008_FFFF_DFF7);
        push_load(1'b0, 64'h800,  64'h0000_0800_FFFF_F7FF);
`else
        push_load(1'b0, 64'h400,  64'h0000_0400_FFFF_FBFF);
        push_load(1'b0, 64'h500,  64'h0000_0500_FFFF_FAFF);
        push_load(1'b0, 64'h600,  64'h0000_0600_FFFF_F9FF);
        push_load(1'b0, 64'h700,  64'h0000_0700_FFFF_F8FF);
        push_load(1'b0, 64'h800,  64'h0000_0800_FFFF_F7FF);
        push_load(1'b1, 64'h2000, 64'h0000_2000_FFFF_DFFF);
        push_load(1'b1, 64'h2008, 64'h0000_2008_FFFF_DFF7);
`endif
        fork
            begin
                mem_op(1'b0, 64'h400, 64'h0);
                mem_op(1'b0, 64'h500, 64'h0);
                mem_op(1'b0, 64'h600, 64'h0);
                mem_op(1'b0, 64'h700, 64'h0);
                mem_op(1'b0, 64'h800, 64'h0);
                memread_mem = 1'b0;
            end
            begin
                if_op(64'h2000);
                if_op(64'h2008);
                if_req = 1'b0;
            end
        join
        cyc_next();

        // Reset while a load waits on the bus.
        wait_target = 1000;
        memread_mem = 1'b1; alu_result_mem = 64'h900;
        cyc_next();
        @(negedge clk);
        chk("rstmid_bus_req_before", 64'(bus_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_bus_req", 64'(bus_req), 64'd0);
        chk("rstmid_acks", 64'({if_ack, mem_ack}), 64'd0);
        chk("rstmid_if_rdata", if_rdata, 64'd0);
        chk("rstmid_mem_rdata", mem_rdata, 64'd0);
        chk("rstmid_bus_addr", bus_addr, 64'd0);
        wait_target = 0;
        push_load(1'b0, 64'h900, 64'h0000_0900_FFFF_F6FF);
        @(posedge clk); #1 rst_n = 1'b1;
        mem_op(1'b0, 64'h900, 64'h0);
        memread_mem = 1'b0;
        cyc_next();

        // Quiet bus.
        for (int c = 0; c < 10; c++) begin
            cyc_next();
            @(negedge clk);
            chk($sformatf("idle_outputs_c%0d", c), 64'({bus_req, stall_if, stall_pipe, if_ack, mem_ack}), 64'd0);
        end

        chk("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        chk("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
